timer_sched_ctrl: RTL and testbench
===================================

Name: timer_sched_ctrl

Overview:
- Avalon-MM master that sequences the 16-bit-halfword interval timer slave so client logic never drives raw register accesses.
- Accepts START/STOP/SNAP commands over a valid/ready port and translates them into timer register write/read bursts.
- Services the timer irq: clears status, pulses tick and counts timeouts.
- Sits between fabric-side client logic (game loop, frame pacing) and the timer instance.

Parameters:
TICK_W, 16, width of tick_count; wraps modulo 2^TICK_W.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge.
cmd_op  in  2  0=START, 1=STOP, 2=SNAP, 3=reserved (accepted, no bus activity).
cmd_period  in  64  START period value, sampled at accept.
cmd_continuous  in  1  START continuous-mode bit, sampled at accept.
snap_valid  out  1  one-cycle pulse: snap_value updated.
snap_value  out  64  last captured counter snapshot.
tick  out  1  one-cycle pulse per serviced timeout.
tick_count  out  TICK_W  serviced timeouts since last START.
busy  out  1  FSM not in IDLE.
tmr_address  out  4  timer register address.
tmr_chipselect  out  1  timer chipselect.
tmr_write_n  out  1  timer write strobe, active low.
tmr_writedata  out  16  timer write data.
tmr_readdata  in  16  timer read data, registered in slave: address in cycle N -> data valid in cycle N+1.
tmr_irq  in  1  timer interrupt (level).

Behaviour:
- Timer register map, fixed: 0 STATUS (write clears timeout), 1 CONTROL {STOP[3], START[2], CONT[1], ITO[0]}, 2..5 PERIOD halfwords 0..3 (LSB first), 6..9 SNAP halfwords 0..3 (a write to any SNAP address captures the counter).
- All bus outputs are registered.
- Idle bus state: chipselect=0, write_n=1, address=0, writedata=0.
- Reset values: all outputs 0, except tmr_write_n=1; cmd_ready is 1 after reset when tmr_irq=0. Reset mid-burst aborts the burst immediately and returns the FSM to IDLE.
- cmd_ready = (state==IDLE) && !tmr_irq.
- IRQ has priority: if tmr_irq=1 in IDLE, no command is accepted that cycle.
- Command accepted at edge T; the first bus beat occurs in cycle T+1.
- FSM states: IDLE, WR_PER, WR_CTRL, CLR_STS, IRQ_HOLD, SNAP_WR, SNAP_RD, SNAP_DONE.
- START: WR_PER issues 4 consecutive writes (addr 2..5, cmd_period[15:0] first), then WR_CTRL writes addr 1 data {0,1,cont,1} (0x5 or 0x7), then IDLE.
  - The burst takes 5 cycles, T+1..T+5.
  - tick_count clears to 0 at accept.
- STOP: WR_CTRL writes addr 1 data 0x8, then CLR_STS writes addr 0 to drop a pending timeout, then IRQ_HOLD, then IDLE.
- IRQ service, from IDLE with tmr_irq=1:
  - CLR_STS writes addr 0 data 0; tick pulses in the same cycle; tick_count increments and wraps.
  - IRQ_HOLD then holds one cycle, because the slave drops irq one cycle after the clear; this prevents double counting.
  - Return to IDLE.
- SNAP:
  - SNAP_WR writes addr 6 in cycle T+1.
  - SNAP_RD presents addr 6,7,8,9 with chipselect=0 and write_n=1 in cycles T+2..T+5; halfwords are captured at the ends of T+3..T+6.
  - snap_value updates atomically; snap_valid pulses in cycle T+7 (SNAP_DONE); then IDLE.
- If tmr_irq rises during any burst, the burst completes uninterrupted and the irq is serviced from IDLE afterwards.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro TIMER_SCHED_AUTOSTOP_EN.
- Defined:
  - Adds input cmd_limit (TICK_W) sampled at START, and output done (1-cycle pulse).
  - On IRQ service where the incremented tick_count == limit and limit != 0, IRQ_HOLD is followed by the STOP sequence (addr 1 data 0x8, then addr 0); done pulses in the cycle the STOP control write is issued.
- Undefined: neither port exists, and the timer runs until an explicit STOP.

Decomposition:
- Shared package timer_sched_pkg contains:
  - op code constants (START/STOP/SNAP);
  - timer register address constants (ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIOD0=2, ADDR_SNAP0=6);
  - control bit positions and the CTRL_STOP word 0x8;
  - the FSM state enum.
- No sub-module: a single FSM with a 2-bit beat counter for the PERIOD/SNAP bursts is natural.

Test Plan:
- Reset asserted during SNAP_RD -> next cycle: chipselect=0, write_n=1, snap_valid=0, busy=0, tick_count=0; after release with irq=0, cmd_ready=1.
- START period 0x0000_0000_0001_86A0, cont=1 -> writes (2,0x86A0), (3,0x0001), (4,0x0000), (5,0x0000), (1,0x0007) in cycles T+1..T+5; cmd_ready=0 over T+1..T+5.
- Timer model asserts irq, dropping it one cycle after the addr-0 write -> exactly one addr-0 write, one tick pulse, tick_count=1; a second irq gives tick_count=2.
- SNAP with model counter 0x1234_5678_9ABC_DEF0 -> write addr 6 at T+1, reads addr 6..9 at T+2..T+5, snap_valid at T+7 with snap_value=0x1234_5678_9ABC_DEF0.
- cmd_valid (STOP) and irq rising in the same IDLE cycle -> addr-0 clear and tick first, then STOP accepted: (1,0x0008), then (0,0x0000).
- AUTOSTOP_EN, limit=3, three irqs -> after the third tick: write (1,0x0008), done pulse, tick_count=3, no further ticks.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : timer_sched_pkg                                              |
// | Description : Shared op codes, timer register map and FSM states for the   |
// |               interval-timer sequencer.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package timer_sched_pkg;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_SNAP  = 2'd2;

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CONTROL = 4'd1;
    localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
    localparam logic [3:0] ADDR_SNAP0   = 4'd6;

    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    localparam logic [15:0] CTRL_STOP = 16'h0008;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_PER    = 3'd1,
        WR_CTRL   = 3'd2,
        CLR_STS   = 3'd3,
        IRQ_HOLD  = 3'd4,
        SNAP_WR   = 3'd5,
        SNAP_RD   = 3'd6,
        SNAP_DONE = 3'd7
    } state_t;

    function automatic logic [15:0] ctrl_start_word(input logic cont);
        logic [15:0] w;
        w                 = 16'h0000;
        w[CTRL_START_BIT] = 1'b1;
        w[CTRL_CONT_BIT]  = cont;
        w[CTRL_ITO_BIT]   = 1'b1;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_sched_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : timer_sched_ctrl                                             |
// | Description : Avalon-MM master sequencing a 16-bit-halfword interval timer:|
// |               START/STOP/SNAP commands and timeout IRQ servicing.          |
// |               Optional auto-stop after N ticks: TIMER_SCHED_AUTOSTOP_EN.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module timer_sched_ctrl
    import timer_sched_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [63:0]       cmd_period,
    input  logic              cmd_continuous,
`ifdef TIMER_SCHED_AUTOSTOP_EN
    input  logic [TICK_W-1:0] cmd_limit,
    output logic              done,
`endif
    output logic              snap_valid,
    output logic [63:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic [3:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
);

    state_t              r_state;
    logic [1:0]          r_beat;
    logic                r_tail;
    logic                r_stop;
    logic [63:0]         r_period;
    logic                r_cont;
    logic [3:0]          r_addr;
    logic                r_cs;
    logic                r_wrn;
    logic [15:0]         r_wd;
    logic                r_tick;
    logic [TICK_W-1:0]   r_tick_count;
    logic                r_snap_valid;
    logic [63:0]         r_snap_value;
    logic [47:0]         r_snap_buf;
    logic                r_rd_pend;
    logic [1:0]          r_rd_idx;
`ifdef TIMER_SCHED_AUTOSTOP_EN
    logic [TICK_W-1:0]   r_limit;
    logic                r_pend;
    logic                r_done;
    logic                w_pend_n;
    logic                w_done_n;
`endif

    state_t              w_state_n;
    logic [1:0]          w_beat_n;
    logic                w_tail_n;
    logic                w_stop_n;
    logic [3:0]          w_addr_n;
    logic                w_cs_n;
    logic                w_wrn_n;
    logic [15:0]         w_wd_n;
    logic                w_tick_n;
    logic                w_snapv_n;
    logic                w_start_acc;
    logic [TICK_W-1:0]   w_cnt_inc;

    assign w_cnt_inc = r_tick_count + 1'b1;

    always_comb begin
        w_state_n   = r_state;
        w_beat_n    = r_beat;
        w_tail_n    = 1'b0;
        w_stop_n    = r_stop;
        w_addr_n    = 4'd0;
        w_cs_n      = 1'b0;
        w_wrn_n     = 1'b1;
        w_wd_n      = 16'h0000;
        w_tick_n    = 1'b0;
        w_snapv_n   = 1'b0;
        w_start_acc = 1'b0;
`ifdef TIMER_SCHED_AUTOSTOP_EN
        w_pend_n    = r_pend;
        w_done_n    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // A pending timeout always wins over a new command.
                if (tmr_irq) begin
                    w_state_n = CLR_STS;
                    w_cs_n    = 1'b1;
                    w_wrn_n   = 1'b0;
                    w_addr_n  = ADDR_STATUS;
                    w_tick_n  = 1'b1;
`ifdef TIMER_SCHED_AUTOSTOP_EN
                    w_pend_n  = (w_cnt_inc == r_limit) && (r_limit != '0);
`endif
                end else if (cmd_valid) begin
                    case (cmd_op)
                        OP_START: begin
                            w_start_acc = 1'b1;
                            w_state_n   = WR_PER;
                            w_beat_n    = 2'd0;
                            w_cs_n      = 1'b1;
                            w_wrn_n     = 1'b0;
                            w_addr_n    = ADDR_PERIOD0;
                            w_wd_n      = cmd_period[15:0];
                        end
                        OP_STOP: begin
                            w_state_n = WR_CTRL;
                            w_stop_n  = 1'b1;
                            w_cs_n    = 1'b1;
                            w_wrn_n   = 1'b0;
                            w_addr_n  = ADDR_CONTROL;
                            w_wd_n    = CTRL_STOP;
                        end
                        OP_SNAP: begin
                            w_state_n = SNAP_WR;
                            w_cs_n    = 1'b1;
                            w_wrn_n   = 1'b0;
                            w_addr_n  = ADDR_SNAP0;
                        end
                        default: ;
                    endcase
                end
            end
            WR_PER: begin
                w_cs_n  = 1'b1;
                w_wrn_n = 1'b0;
                if (r_beat == 2'd3) begin
                    w_state_n = WR_CTRL;
                    w_stop_n  = 1'b0;
                    w_addr_n  = ADDR_CONTROL;
                    w_wd_n    = ctrl_start_word(r_cont);
                end else begin
                    w_beat_n = r_beat + 2'd1;
                    w_addr_n = ADDR_PERIOD0 + {2'b00, w_beat_n};
                    w_wd_n   = r_period[{w_beat_n, 4'b0000} +: 16];
                end
            end
            WR_CTRL: begin
                if (r_stop) begin
                    w_state_n = CLR_STS;
                    w_cs_n    = 1'b1;
                    w_wrn_n   = 1'b0;
                    w_addr_n  = ADDR_STATUS;
                end else begin
                    w_state_n = IDLE;
                end
            end
            CLR_STS: w_state_n = IRQ_HOLD;
            IRQ_HOLD: begin
                // The slave drops irq a cycle after the clear; waiting here avoids a double count.
                w_state_n = IDLE;
`ifdef TIMER_SCHED_AUTOSTOP_EN
                if (r_pend) begin
                    w_state_n = WR_CTRL;
                    w_stop_n  = 1'b1;
                    w_pend_n  = 1'b0;
                    w_done_n  = 1'b1;
                    w_cs_n    = 1'b1;
                    w_wrn_n   = 1'b0;
                    w_addr_n  = ADDR_CONTROL;
                    w_wd_n    = CTRL_STOP;
                end
`endif
            end
            SNAP_WR: begin
                w_state_n = SNAP_RD;
                w_beat_n  = 2'd0;
                w_addr_n  = ADDR_SNAP0;
            end
            SNAP_RD: begin
                // One trailing cycle lets the last registered halfword arrive.
                if (r_tail) begin
                    w_state_n = SNAP_DONE;
                    w_snapv_n = 1'b1;
                end else if (r_beat == 2'd3) begin
                    w_tail_n = 1'b1;
                end else begin
                    w_beat_n = r_beat + 2'd1;
                    w_addr_n = ADDR_SNAP0 + {2'b00, w_beat_n};
                end
            end
            SNAP_DONE: w_state_n = IDLE;
            default:   w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beat       <= 2'd0;
            r_tail       <= 1'b0;
            r_stop       <= 1'b0;
            r_period     <= 64'd0;
            r_cont       <= 1'b0;
            r_addr       <= 4'd0;
            r_cs         <= 1'b0;
            r_wrn        <= 1'b1;
            r_wd         <= 16'h0000;
            r_tick       <= 1'b0;
            r_tick_count <= '0;
            r_snap_valid <= 1'b0;
            r_snap_value <= 64'd0;
            r_snap_buf   <= 48'd0;
            r_rd_pend    <= 1'b0;
            r_rd_idx     <= 2'd0;
`ifdef TIMER_SCHED_AUTOSTOP_EN
            r_limit      <= '0;
            r_pend       <= 1'b0;
            r_done       <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_beat       <= w_beat_n;
            r_tail       <= w_tail_n;
            r_stop       <= w_stop_n;
            r_addr       <= w_addr_n;
            r_cs         <= w_cs_n;
            r_wrn        <= w_wrn_n;
            r_wd         <= w_wd_n;
            r_tick       <= w_tick_n;
            r_snap_valid <= w_snapv_n;
            r_rd_pend    <= (r_state == SNAP_RD) && !r_tail;
            r_rd_idx     <= r_beat;
            if (r_rd_pend) begin
                if (r_rd_idx == 2'd3) begin
                    r_snap_value <= {tmr_readdata, r_snap_buf};
                end else begin
                    r_snap_buf[{r_rd_idx, 4'b0000} +: 16] <= tmr_readdata;
                end
            end
            if (w_start_acc) begin
                r_period     <= cmd_period;
                r_cont       <= cmd_continuous;
                r_tick_count <= '0;
            end else if (w_tick_n) begin
                r_tick_count <= w_cnt_inc;
            end
`ifdef TIMER_SCHED_AUTOSTOP_EN
            if (w_start_acc) begin
                r_limit <= cmd_limit;
            end
            r_pend <= w_start_acc ? 1'b0 : w_pend_n;
            r_done <= w_done_n;
`endif
        end
    end

    assign cmd_ready      = (r_state == IDLE) && !tmr_irq;
    assign busy           = (r_state != IDLE);
    assign tick           = r_tick;
    assign tick_count     = r_tick_count;
    assign snap_valid     = r_snap_valid;
    assign snap_value     = r_snap_value;
    assign tmr_address    = r_addr;
    assign tmr_chipselect = r_cs;
    assign tmr_write_n    = r_wrn;
    assign tmr_writedata  = r_wd;
`ifdef TIMER_SCHED_AUTOSTOP_EN
    assign done           = r_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_sched_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_timer_sched_ctrl                                          |
// | Description : Directed self-checking bench for timer_sched_ctrl.           |
// |               Auto-stop steps are built with TIMER_SCHED_AUTOSTOP_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_timer_sched_ctrl;

    localparam int TICK_W = 16;
    localparam logic [63:0] SNAP_MODEL = 64'h1234_5678_9ABC_DEF0;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [63:0]       cmd_period;
    logic              cmd_continuous;
`ifdef TIMER_SCHED_AUTOSTOP_EN
    logic [TICK_W-1:0] cmd_limit;
    logic              done;
`endif
    logic              snap_valid;
    logic [63:0]       snap_value;
    logic              tick;
    logic [TICK_W-1:0] tick_count;
    logic              busy;
    logic [3:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic [15:0]       tmr_readdata;
    logic              tmr_irq;

    int tests = 0;
    int fails = 0;

    logic [3:0]  st_addr [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    logic [15:0] st_data [5] = '{16'h86A0, 16'h0001, 16'h0000, 16'h0000, 16'h0007};

    always #5 clk = ~clk;

    timer_sched_ctrl #(.TICK_W(TICK_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
`ifdef TIMER_SCHED_AUTOSTOP_EN
        .cmd_limit      (cmd_limit),
        .done           (done),
`endif
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick           (tick),
        .tick_count     (tick_count),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq)
    );

    // Registered slave read path: SNAP halfwords by address, one cycle later.
    always @(posedge clk) begin
        if (tmr_address >= 4'd6 && tmr_address <= 4'd9)
            tmr_readdata <= SNAP_MODEL[{tmr_address[1:0] - 2'd2, 4'b0000} +: 16];
        else
            tmr_readdata <= 16'h0000;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic cs, input logic wn,
                             input logic [3:0] a, input logic [15:0] d);
        check(tag, {42'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
                   {42'd0, cs, wn, a, d});
    endtask

    // Raise irq in IDLE, expect one clear+tick, drop irq during the hold cycle.
    task automatic irq_svc(input logic [TICK_W-1:0] cnt);
        tmr_irq = 1'b1;
        #1;
        check("irq_rdy", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        check_bus("irq_clr", 1'b1, 1'b0, 4'd0, 16'h0000);
        check("irq_tick", {63'd0, tick}, 64'd1);
        check("irq_cnt", {48'd0, tick_count}, {48'd0, cnt});
        @(negedge clk);
        tmr_irq = 1'b0;
        check("irq_hold_tick", {63'd0, tick}, 64'd0);
        check("irq_hold_busy", {63'd0, busy}, 64'd1);
        check_bus("irq_hold_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
    endtask

    task automatic do_start(input logic [63:0] per, input logic cont);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = per; cmd_continuous = cont;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = 64'd0;
        cmd_continuous = 1'b0; tmr_irq = 1'b0;
`ifdef TIMER_SCHED_AUTOSTOP_EN
        cmd_limit = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check_bus("rst_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("rst_tick", {63'd0, tick}, 64'd0);
        check("rst_tickcnt", {48'd0, tick_count}, 64'd0);
        check("rst_snapv", {63'd0, snap_valid}, 64'd0);
        check("rst_snapval", snap_value, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdy", {63'd0, cmd_ready}, 64'd1);

        // START, period 100000, continuous
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = 64'h0000_0000_0001_86A0; cmd_continuous = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check_bus($sformatf("start_beat%0d", i), 1'b1, 1'b0, st_addr[i], st_data[i]);
            check($sformatf("start_rdy%0d", i), {63'd0, cmd_ready}, 64'd0);
        end
        @(negedge clk);
        check_bus("start_end_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("start_end_busy", {63'd0, busy}, 64'd0);
        check("start_end_rdy", {63'd0, cmd_ready}, 64'd1);

        // Two serviced timeouts
        irq_svc(16'd1);
        @(negedge clk);
        check_bus("irq1_after_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("irq1_after_busy", {63'd0, busy}, 64'd0);
        check("irq1_after_cnt", {48'd0, tick_count}, 64'd1);
        irq_svc(16'd2);
        @(negedge clk);
        check("irq2_after_cnt", {48'd0, tick_count}, 64'd2);
        check("irq2_after_tick", {63'd0, tick}, 64'd0);

        // SNAP
        cmd_valid = 1'b1; cmd_op = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_bus("snap_wr", 1'b1, 1'b0, 4'd6, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bus($sformatf("snap_rd%0d", i), 1'b0, 1'b1, 4'(6 + i), 16'h0000);
        end
        @(negedge clk);
        check("snap_t6_valid", {63'd0, snap_valid}, 64'd0);
        check("snap_t6_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("snap_t7_valid", {63'd0, snap_valid}, 64'd1);
        check("snap_t7_value", snap_value, SNAP_MODEL);
        check("snap_t7_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("snap_t8_valid", {63'd0, snap_valid}, 64'd0);
        check("snap_t8_busy", {63'd0, busy}, 64'd0);

        // Reserved op: accepted, no bus activity
        cmd_valid = 1'b1; cmd_op = 2'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_bus("rsv_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("rsv_busy", {63'd0, busy}, 64'd0);

        // STOP and irq in the same IDLE cycle: irq serviced first
        tmr_irq = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1;
        #1;
        check("stopirq_rdy0", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        check_bus("stopirq_clr", 1'b1, 1'b0, 4'd0, 16'h0000);
        check("stopirq_tick", {63'd0, tick}, 64'd1);
        check("stopirq_cnt", {48'd0, tick_count}, 64'd3);
        @(negedge clk);
        tmr_irq = 1'b0;
        check("stopirq_hold_tick", {63'd0, tick}, 64'd0);
        @(negedge clk);
        check("stopirq_rdy1", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_bus("stop_ctrl", 1'b1, 1'b0, 4'd1, 16'h0008);
        @(negedge clk);
        check_bus("stop_clr", 1'b1, 1'b0, 4'd0, 16'h0000);
        check("stop_clr_tick", {63'd0, tick}, 64'd0);
        @(negedge clk);
        check("stop_hold_busy", {63'd0, busy}, 64'd1);
        check_bus("stop_hold_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        @(negedge clk);
        check("stop_end_busy", {63'd0, busy}, 64'd0);
        check("stop_end_cnt", {48'd0, tick_count}, 64'd3);

        // Reset in the middle of SNAP_RD
        cmd_valid = 1'b1; cmd_op = 2'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_bus("rsnap_rd", 1'b0, 1'b1, 4'd7, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        check_bus("rsnap_bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("rsnap_snapv", {63'd0, snap_valid}, 64'd0);
        check("rsnap_busy", {63'd0, busy}, 64'd0);
        check("rsnap_cnt", {48'd0, tick_count}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rsnap_rdy", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        check("rsnap_idle_snapv", {63'd0, snap_valid}, 64'd0);

`ifdef TIMER_SCHED_AUTOSTOP_EN
        // Auto-stop after three ticks
        cmd_limit = 16'd3;
        do_start(64'h10, 1'b1);
        repeat (5) @(negedge clk);
        check("as_start_busy", {63'd0, busy}, 64'd0);
        irq_svc(16'd1);
        @(negedge clk);
        check("as_irq1_busy", {63'd0, busy}, 64'd0);
        irq_svc(16'd2);
        @(negedge clk);
        check("as_irq2_busy", {63'd0, busy}, 64'd0);
        irq_svc(16'd3);
        @(negedge clk);
        check_bus("as_stop_ctrl", 1'b1, 1'b0, 4'd1, 16'h0008);
        check("as_done", {63'd0, done}, 64'd1);
        @(negedge clk);
        check_bus("as_stop_clr", 1'b1, 1'b0, 4'd0, 16'h0000);
        check("as_done_clr", {63'd0, done}, 64'd0);
        check("as_clr_tick", {63'd0, tick}, 64'd0);
        @(negedge clk);
        check("as_hold_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("as_quiet_tick%0d", i), {63'd0, tick}, 64'd0);
            check($sformatf("as_quiet_busy%0d", i), {63'd0, busy}, 64'd0);
        end
        check("as_final_cnt", {48'd0, tick_count}, 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
